// File: rtl/buyruk_paketleyici.sv
// buyruk_paketleyici: packs 16/32-bit RISC-V instructions into aligned 32-bit words; define BUYRUK_SAYAC_EN to add an accepted-instruction counter
module buyruk_paketleyici #(
  parameter int ADRES_W = 10,
  parameter logic [15:0] DOLGU = 16'h0001
`ifdef BUYRUK_SAYAC_EN
  , parameter int SAYAC_W = 16
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        buyruk_i,
  input  logic               buyruk_gecerli_i,
  output logic               buyruk_hazir_o,
  input  logic               bosalt_i,
  output logic               bosalt_tamam_o,
  output logic [31:0]        kelime_o,
  output logic               kelime_gecerli_o,
  input  logic               kelime_hazir_i,
  output logic [ADRES_W-1:0] adres_o
`ifdef BUYRUK_SAYAC_EN
  , output logic [SAYAC_W-1:0] buyruk_sayisi_o
`endif
);
  typedef enum logic {BOS, YARIM} durum_t;
  durum_t      durum;
  logic [15:0] tut_r;
  logic        slot_bos, kabul, len32, yarim_bosalt, emit, cikis_el;
  logic [31:0] yeni;
  // handshake decode and next output word; a held low halfword always sits in the lower half
  always_comb begin
    slot_bos       = !kelime_gecerli_o || kelime_hazir_i;
    buyruk_hazir_o = slot_bos && !bosalt_i;
    kabul          = buyruk_gecerli_i && buyruk_hazir_o;
    len32          = buyruk_i[1:0] == 2'b11;
    cikis_el       = kelime_gecerli_o && kelime_hazir_i;
    yarim_bosalt   = bosalt_i && durum == YARIM && slot_bos;
    emit           = (kabul && (len32 || durum == YARIM)) || yarim_bosalt;
    yeni           = bosalt_i ? {DOLGU, tut_r} : durum == BOS ? buyruk_i : {buyruk_i[15:0], tut_r};
    bosalt_tamam_o = durum == BOS && !kelime_gecerli_o;
  end
  // packer state, carried halfword, output register and word address
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum            <= BOS;
      tut_r            <= '0;
      kelime_o         <= '0;
      kelime_gecerli_o <= 1'b0;
      adres_o          <= '0;
    end else begin
      if (cikis_el) adres_o <= adres_o + 1'b1;
      if (emit) begin
        kelime_o         <= yeni;
        kelime_gecerli_o <= 1'b1;
      end else if (cikis_el) kelime_gecerli_o <= 1'b0;
      if (yarim_bosalt) durum <= BOS;
      else if (kabul) begin
        if (durum == BOS && !len32) begin
          tut_r <= buyruk_i[15:0];
          durum <= YARIM;
        end else if (durum == YARIM && !len32) durum <= BOS;
        else if (durum == YARIM) tut_r <= buyruk_i[31:16];
      end
    end
  end
`ifdef BUYRUK_SAYAC_EN
  // saturating count of accepted instructions
  always_ff @(posedge clk_i) begin
    if (rst_i) buyruk_sayisi_o <= '0;
    else if (kabul && buyruk_sayisi_o != '1) buyruk_sayisi_o <= buyruk_sayisi_o + 1'b1;
  end
`endif
endmodule

// File: tb/tb_buyruk_paketleyici.sv
// tb_buyruk_paketleyici: directed and random stimulus against a halfword-queue reference model
module tb_buyruk_paketleyici;
  localparam int AW = 10;
  logic          clk = 1'b0;
  logic          rst_i, buyruk_gecerli_i, buyruk_hazir_o, bosalt_i, bosalt_tamam_o;
  logic          kelime_gecerli_o, kelime_hazir_i;
  logic [31:0]   buyruk_i, kelime_o;
  logic [AW-1:0] adres_o;
`ifdef BUYRUK_SAYAC_EN
  localparam int SW = 2;
  logic [SW-1:0] buyruk_sayisi;
`endif
  logic [15:0]   hq[$];
  logic [31:0]   wq[$];
  logic [AW-1:0] exp_adr;
  int            exp_cnt;
  bit            acc;
  int            errors = 0, checks = 0;

  always #5 clk = ~clk;

  buyruk_paketleyici #(.ADRES_W(AW), .DOLGU(16'h0001)
`ifdef BUYRUK_SAYAC_EN
    , .SAYAC_W(SW)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .buyruk_i(buyruk_i), .buyruk_gecerli_i(buyruk_gecerli_i),
    .buyruk_hazir_o(buyruk_hazir_o), .bosalt_i(bosalt_i), .bosalt_tamam_o(bosalt_tamam_o),
    .kelime_o(kelime_o), .kelime_gecerli_o(kelime_gecerli_o), .kelime_hazir_i(kelime_hazir_i),
    .adres_o(adres_o)
`ifdef BUYRUK_SAYAC_EN
    , .buyruk_sayisi_o(buyruk_sayisi)
`endif
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // reference: accepted instructions become halfwords; every two halfwords form one word
  task automatic observe();
    bit slot;
    acc = 0;
    if (rst_i) begin
      hq.delete();
      wq.delete();
      exp_adr = '0;
      exp_cnt = 0;
      return;
    end
    slot = wq.size() == 0 || kelime_hazir_i;
    chk("gecerli", kelime_gecerli_o, wq.size() != 0);
    chk("tamam", bosalt_tamam_o, hq.size() == 0 && wq.size() == 0);
    chk("hazir", buyruk_hazir_o, slot && !bosalt_i);
`ifdef BUYRUK_SAYAC_EN
    chk("sayac", buyruk_sayisi, exp_cnt);
`endif
    if (kelime_gecerli_o && kelime_hazir_i && wq.size() != 0) begin
      chk("kelime", kelime_o, wq.pop_front());
      chk("adres", adres_o, exp_adr);
      exp_adr++;
    end
    if (buyruk_gecerli_i && buyruk_hazir_o) begin
      acc = 1;
      hq.push_back(buyruk_i[15:0]);
      if (buyruk_i[1:0] == 2'b11) hq.push_back(buyruk_i[31:16]);
      if (exp_cnt < 3) exp_cnt++;
    end else if (bosalt_i && hq.size() == 1 && slot) hq.push_back(16'h0001);
    while (hq.size() >= 2) begin
      wq.push_back({hq[1], hq[0]});
      void'(hq.pop_front());
      void'(hq.pop_front());
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] b);
    int n = 0;
    buyruk_i = b;
    buyruk_gecerli_i = 1'b1;
    do begin
      cyc();
      n++;
    end while (!acc && n < 200);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout got=not_accepted want=accepted instr=%h", b);
    end
    buyruk_gecerli_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    buyruk_gecerli_i = 1'b0;
    bosalt_i = 1'b0;
    kelime_hazir_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    bit pend;
    buyruk_i = '0;
    r = '0;
    pend = 0;
    do_reset();
    chk("reset_kelime", kelime_o, 0);
    chk("reset_gecerli", kelime_gecerli_o, 0);
    chk("reset_adres", adres_o, 0);
    chk("reset_tamam", bosalt_tamam_o, 1);
    chk("reset_hazir", buyruk_hazir_o, 1);
    repeat (4) send(32'h00000013);
    repeat (2) cyc();
    chk("t1_adres", adres_o, 4);
    do_reset();
    send(32'h00004501);
    chk("t2_no_out", kelime_gecerli_o, 0);
    send(32'h00004585);
    chk("t2_kelime", kelime_o, 32'h45854501);
    chk("t2_adres", adres_o, 0);
    cyc();
    do_reset();
    send(32'h00004501);
    send(32'h00A00093);
    chk("t3_kelime", kelime_o, 32'h00934501);
    bosalt_i = 1'b1;
    cyc();
    chk("t3_pad", kelime_o, 32'h000100A0);
    chk("t3_tamam0", bosalt_tamam_o, 0);
    cyc();
    chk("t3_tamam1", bosalt_tamam_o, 1);
    bosalt_i = 1'b0;
    cyc();
    kelime_hazir_i = 1'b0;
    send(32'h00000013);
    buyruk_i = 32'h00000093;
    buyruk_gecerli_i = 1'b1;
    repeat (5) begin
      cyc();
      chk("t4_hazir", buyruk_hazir_o, 0);
      chk("t4_kelime", kelime_o, 32'h00000013);
      chk("t4_adres", adres_o, exp_adr);
    end
    kelime_hazir_i = 1'b1;
    cyc();
    buyruk_gecerli_i = 1'b0;
    repeat (2) cyc();
    do_reset();
    repeat (1024) send(32'h00000013);
    chk("t5_adres_max", adres_o, 1023);
    send(32'h00000013);
    chk("t5_adres_wrap", adres_o, 0);
    cyc();
    send(32'h00004501);
    rst_i = 1'b1;
    bosalt_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    repeat (3) cyc();
    chk("t5_rst_kelime", kelime_o, 0);
    chk("t5_rst_gecerli", kelime_gecerli_o, 0);
    chk("t5_rst_adres", adres_o, 0);
    bosalt_i = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        r = $urandom;
        r[1:0] = $urandom_range(0, 1) == 1 ? 2'($urandom_range(0, 2)) : 2'b11;
        pend = 1;
      end
      buyruk_i = r;
      buyruk_gecerli_i = pend;
      kelime_hazir_i = $urandom_range(0, 3) != 0;
      bosalt_i = $urandom_range(0, 9) == 0;
      cyc();
      if (acc) pend = 0;
    end
    buyruk_gecerli_i = 1'b0;
    kelime_hazir_i = 1'b1;
    bosalt_i = 1'b1;
    repeat (4) cyc();
    bosalt_i = 1'b0;
    chk("drain_tamam", bosalt_tamam_o, 1);
`ifdef BUYRUK_SAYAC_EN
    begin
      int want[5] = '{1, 2, 3, 3, 3};
      do_reset();
      for (int i = 0; i < 5; i++) begin
        send(32'h00000013);
        chk("t6_sayac", buyruk_sayisi, want[i]);
      end
      cyc();
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
